// File: rtl/l2_bus_adapter_if.sv
// L2 block side and word-wide memory side of the L2 bus adapter.
// slave = adapter view, master = the bus controller / memory environment view.
interface l2_bus_adapter_if #(parameter int BLOCK_SIZE = 2);
  logic                    l2REN;
  logic                    l2WEN;
  logic [31:0]             l2addr;
  logic [32*BLOCK_SIZE-1:0] l2store;
  logic [32*BLOCK_SIZE-1:0] l2load;
  logic [1:0]              l2state;
  logic [31:0]             mem_addr;
  logic                    mem_ren;
  logic                    mem_wen;
  logic [31:0]             mem_wdata;
  logic [31:0]             mem_rdata;
  logic                    mem_busy;
  logic [3:0]              mem_byte_en;

  modport slave (
    input  l2REN, l2WEN, l2addr, l2store, mem_rdata, mem_busy,
    output l2load, l2state, mem_addr, mem_ren, mem_wen, mem_wdata, mem_byte_en
  );

  modport master (
    output l2REN, l2WEN, l2addr, l2store, mem_rdata, mem_busy,
    input  l2load, l2state, mem_addr, mem_ren, mem_wen, mem_wdata, mem_byte_en
  );
endinterface

// File: rtl/l2_bus_adapter.sv
// Splits an L2 block read/write into BLOCK_SIZE word beats on the memory bus.
// Optional L2_ADAPTER_ALIGN_CHECK_EN rejects misaligned block addresses via ERR.
module l2_bus_adapter #(
  parameter int BLOCK_SIZE = 2
) (
  input  logic            CLK,
  input  logic            nRST,
  l2_bus_adapter_if.slave bus
);
  localparam int CW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int LB = $clog2(4*BLOCK_SIZE);
  localparam logic [CW-1:0] LAST = CW'(BLOCK_SIZE-1);
`ifdef L2_ADAPTER_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  // Encodings line up with L2_FREE/BUSY/ACCESS/ERROR so l2state is the state itself.
  typedef enum logic [1:0] {IDLE = 2'd0, BEAT = 2'd1, DONE = 2'd2, ERR = 2'd3} state_t;

  state_t                       r_state;
  logic [CW-1:0]                r_beat;
  logic                         r_wr;
  logic [31:0]                  r_base;
  logic [BLOCK_SIZE-1:0][31:0]  r_data;
  logic [BLOCK_SIZE-1:0][31:0]  r_load;
  logic                         w_misalign;
  logic [31:0]                  w_off;

  assign w_misalign      = ALIGN_CHK && (|bus.l2addr[LB-1:0]);
  assign w_off           = {{(30-CW){1'b0}}, r_beat, 2'b00};
  assign bus.mem_addr    = r_base + w_off;
  assign bus.mem_wdata   = r_data[r_beat];
  assign bus.mem_ren     = (r_state == BEAT) && !r_wr;
  assign bus.mem_wen     = (r_state == BEAT) && r_wr;
  assign bus.mem_byte_en = 4'hF;
  assign bus.l2state     = r_state;
  assign bus.l2load      = r_load;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_wr    <= 1'b0;
      r_base  <= '0;
      r_data  <= '0;
      r_load  <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.l2REN || bus.l2WEN) begin
          if (w_misalign) begin
            r_state <= ERR;
          end else begin
            r_state <= BEAT;
            r_beat  <= '0;
            r_wr    <= bus.l2WEN;
            r_base  <= {bus.l2addr[31:LB], {LB{1'b0}}};
            r_data  <= bus.l2store;
          end
        end
        BEAT: if (!bus.mem_busy) begin
          if (!r_wr) r_load[r_beat] <= bus.mem_rdata;
          if (r_beat == LAST) begin
            r_state <= DONE;
            r_beat  <= '0;
          end else begin
            r_beat  <= r_beat + 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        ERR:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l2_bus_adapter.sv
// Directed table-driven bench for l2_bus_adapter (BLOCK_SIZE=2) plus multi-cycle sequences.
module tb_l2_bus_adapter;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  l2_bus_adapter_if #(.BLOCK_SIZE(2)) bus ();
  l2_bus_adapter #(.BLOCK_SIZE(2)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [63:0] store;
    logic [31:0] rd0;
    logic [31:0] rd1;
    int          stall;
    logic [1:0]  exp_state;
    int          exp_cyc;
    int          exp_beats;
    logic        exp_wr;
    logic [31:0] exp_a0;
    logic [31:0] exp_a1;
    logic [31:0] exp_d0;
    logic [31:0] exp_d1;
    logic [63:0] exp_load;
  } vec_t;

  vec_t vtab [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int idx);
    int cyc, beat, nbeats, stab_bad, strobe_bad;
    logic busy_now, first;
    logic [31:0] a [2];
    logic [31:0] d [2];
    logic        w [2];
    a = '{default: '0}; d = '{default: '0}; w = '{default: 1'b0};
    nbeats = 0; stab_bad = 0; strobe_bad = 0; beat = 0; first = 1'b1;
    @(negedge CLK);
    bus.l2REN = v.ren; bus.l2WEN = v.wen; bus.l2addr = v.addr; bus.l2store = v.store;
    bus.mem_busy = 1'b0;
    @(posedge CLK); #1;
    bus.l2REN = 1'b0; bus.l2WEN = 1'b0;
    cyc = 1;
    while (bus.l2state == 2'd1 && cyc < 30) begin
      if (!(bus.mem_ren ^ bus.mem_wen)) strobe_bad++;
      if (beat < 2) begin
        if (first) begin
          a[beat] = bus.mem_addr; d[beat] = bus.mem_wdata; w[beat] = bus.mem_wen;
          nbeats++;
        end else if (bus.mem_addr !== a[beat] || bus.mem_wdata !== d[beat] || bus.mem_wen !== w[beat]) begin
          stab_bad++;
        end
      end
      busy_now = (v.stall > 0 && beat == 0 && (cyc <= v.stall));
      bus.mem_busy  = busy_now;
      bus.mem_rdata = (beat == 0) ? v.rd0 : v.rd1;
      @(posedge CLK); #1;
      first = !busy_now;
      if (!busy_now) beat++;
      cyc++;
    end
    bus.mem_busy = 1'b0;
    chk($sformatf("v%0d end_state", idx), 64'(bus.l2state), 64'(v.exp_state));
    chk($sformatf("v%0d latency", idx), 64'(cyc), 64'(v.exp_cyc));
    chk($sformatf("v%0d beats", idx), 64'(nbeats), 64'(v.exp_beats));
    chk($sformatf("v%0d strobes_at_end", idx), 64'({bus.mem_ren, bus.mem_wen}), 64'(0));
    chk($sformatf("v%0d strobe_excl", idx), 64'(strobe_bad), 64'(0));
    chk($sformatf("v%0d stall_stable", idx), 64'(stab_bad), 64'(0));
    chk($sformatf("v%0d load", idx), bus.l2load, v.exp_load);
    if (v.exp_beats == 2) begin
      chk($sformatf("v%0d addr0", idx), 64'(a[0]), 64'(v.exp_a0));
      chk($sformatf("v%0d addr1", idx), 64'(a[1]), 64'(v.exp_a1));
      chk($sformatf("v%0d is_write", idx), 64'({w[1], w[0]}), 64'({v.exp_wr, v.exp_wr}));
      if (v.exp_wr) begin
        chk($sformatf("v%0d wdata0", idx), 64'(d[0]), 64'(v.exp_d0));
        chk($sformatf("v%0d wdata1", idx), 64'(d[1]), 64'(v.exp_d1));
      end
    end
    @(posedge CLK); #1;
    chk($sformatf("v%0d back_free", idx), 64'(bus.l2state), 64'(0));
  endtask

  initial begin
    logic [1:0] st [6];
    int wait_c;
    bus.l2REN = 1'b0; bus.l2WEN = 1'b0; bus.l2addr = '0; bus.l2store = '0;
    bus.mem_rdata = '0; bus.mem_busy = 1'b0;

    //            ren  wen  addr          store                   rd0           rd1           stall st  cyc beats wr  a0            a1            d0            d1            load
    vtab[0] = '{1'b1,1'b0,32'h0000_0100,64'h0,                  32'hAAAA_0000,32'hBBBB_0001,0,  2'd2,3, 2, 1'b0,32'h0000_0100,32'h0000_0104,32'h0,        32'h0,        64'hBBBB0001_AAAA0000};
    vtab[1] = '{1'b0,1'b1,32'h0000_0208,64'h12345678_9ABCDEF0,32'h0,        32'h0,        0,  2'd2,3, 2, 1'b1,32'h0000_0208,32'h0000_020C,32'h9ABC_DEF0,32'h1234_5678,64'hBBBB0001_AAAA0000};
    vtab[2] = '{1'b1,1'b0,32'h0000_0100,64'h0,                  32'h1111_1111,32'h2222_2222,3,  2'd2,6, 2, 1'b0,32'h0000_0100,32'h0000_0104,32'h0,        32'h0,        64'h22222222_11111111};
    vtab[3] = '{1'b1,1'b1,32'h0000_0300,64'hCAFEF00D_DEADBEEF,32'h5555_5555,32'h6666_6666,0,  2'd2,3, 2, 1'b1,32'h0000_0300,32'h0000_0304,32'hDEAD_BEEF,32'hCAFE_F00D,64'h22222222_11111111};
    vtab[4] = '{1'b1,1'b0,32'hFFFF_FFF8,64'h0,                  32'h0000_0005,32'h0000_0006,0,  2'd2,3, 2, 1'b0,32'hFFFF_FFF8,32'hFFFF_FFFC,32'h0,        32'h0,        64'h00000006_00000005};
`ifdef L2_ADAPTER_ALIGN_CHECK_EN
    vtab[5] = '{1'b1,1'b0,32'h0000_0104,64'h0,                  32'h0000_0007,32'h0000_0008,0,  2'd3,1, 0, 1'b0,32'h0,        32'h0,        32'h0,        32'h0,        64'h00000006_00000005};
`else
    vtab[5] = '{1'b1,1'b0,32'h0000_0104,64'h0,                  32'h0000_0007,32'h0000_0008,0,  2'd2,3, 2, 1'b0,32'h0000_0100,32'h0000_0104,32'h0,        32'h0,        64'h00000008_00000007};
`endif

    // Reset state
    #12;
    chk("rst_state", 64'(bus.l2state), 64'(0));
    chk("rst_strobes", 64'({bus.mem_ren, bus.mem_wen}), 64'(0));
    chk("rst_load", bus.l2load, 64'h0);
    chk("byte_en", 64'(bus.mem_byte_en), 64'hF);
    @(negedge CLK); nRST = 1'b1;

    for (int i = 0; i < 6; i++) run(vtab[i], i);

    // Request held high through DONE is re-accepted on the following IDLE cycle
    @(negedge CLK);
    bus.l2REN = 1'b1; bus.l2WEN = 1'b0; bus.l2addr = 32'h0000_0100; bus.mem_rdata = 32'h33; bus.mem_busy = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge CLK); #1;
      st[c] = bus.l2state;
    end
    chk("held_c1", 64'(st[1]), 64'(1));
    chk("held_c2", 64'(st[2]), 64'(1));
    chk("held_c3", 64'(st[3]), 64'(2));
    chk("held_c4", 64'(st[4]), 64'(0));
    chk("held_c5", 64'(st[5]), 64'(1));
    bus.l2REN = 1'b0;
    wait_c = 0;
    while (bus.l2state != 2'd0 && wait_c < 20) begin
      @(posedge CLK); #1;
      wait_c++;
    end
    chk("held_finish", 64'(bus.l2state), 64'(0));
    chk("held_load", bus.l2load, 64'h00000033_00000033);

    // Reset pulse during beat 1 aborts the transfer
    @(negedge CLK);
    bus.l2REN = 1'b1; bus.l2addr = 32'h0000_0100; bus.mem_rdata = 32'h44;
    @(posedge CLK); #1;
    bus.l2REN = 1'b0;
    @(posedge CLK); #1;
    chk("rst_mid_pre_ren", 64'(bus.mem_ren), 64'(1));
    chk("rst_mid_pre_addr", 64'(bus.mem_addr), 64'h104);
    nRST = 1'b0;
    #1;
    chk("rst_mid_ren", 64'(bus.mem_ren), 64'(0));
    chk("rst_mid_state", 64'(bus.l2state), 64'(0));
    chk("rst_mid_load", bus.l2load, 64'h0);
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;
    chk("rst_mid_no_access", 64'(bus.l2state), 64'(0));
    run(vtab[0], 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
